// File: rtl/sync_pkg.sv
// Shared definitions for the multi-channel input synchronizer/filter.
//   cnt_width(n) : width of a counter that must hold values 0..n (at least 1 bit)
//   DEF_*        : default parameter values used by sync_filter_chan / sync_filter_multi
package sync_pkg;

    localparam int DEF_NUM_CH        = 4;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_FILTER_CYCLES = 3;

    function automatic int cnt_width(input int n);
        int w;
        w = (n <= 0) ? 1 : $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// Single channel: SYNC_STAGES-deep metastability chain, optional stable-count
// glitch filter and registered rise/fall edge pulses.
//   clk        : system clock
//   n_rst      : asynchronous active-low reset
//   async_in   : asynchronous pin
//   sync_out   : synchronized (and filtered) level
//   rise_pulse : one cycle high on 0->1 of sync_out
//   fall_pulse : one cycle high on 1->0 of sync_out
module sync_filter_chan
    import sync_pkg::*;
#(
    parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int   FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter logic RESET_BIT     = 1'b0
) (
    input  logic clk,
    input  logic n_rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] stage;
    logic                   s_last;
    logic                   sync_lvl;
    logic                   sync_out_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stage <= {SYNC_STAGES{RESET_BIT}};
        end else begin
            stage <= {stage[SYNC_STAGES-2:0], async_in};
        end
    end

    assign s_last = stage[SYNC_STAGES-1];

    generate
        if (FILTER_CYCLES == 0) begin : g_bypass
            // No extra flop: timing identical to a plain N-flop synchronizer.
            assign sync_lvl = s_last;
        end else begin : g_filter
            localparam int              CW       = cnt_width(FILTER_CYCLES);
            localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_CYCLES - 1);

            logic [CW-1:0] cnt;
            logic          lvl;

            // cnt tracks how many consecutive cycles the synced value has
            // disagreed with the output; the N-th disagreement commits it.
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    cnt <= '0;
                    lvl <= RESET_BIT;
                end else if (s_last == lvl) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    lvl <= s_last;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign sync_lvl = lvl;
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_out_d <= RESET_BIT;
        end else begin
            sync_out_d <= sync_lvl;
        end
    end

    // Both operands are flop outputs, so the pulses cannot glitch.
    assign sync_out   = sync_lvl;
    assign rise_pulse = sync_lvl & ~sync_out_d;
    assign fall_pulse = ~sync_lvl & sync_out_d;

endmodule

// File: rtl/sync_filter_multi.sv
// NUM_CH independent synchronizer/filter channels for asynchronous pins.
//   clk        : system clock
//   n_rst      : asynchronous active-low reset
//   async_in   : [NUM_CH] asynchronous inputs
//   sync_out   : [NUM_CH] synchronized, filtered levels
//   rise_pulse : [NUM_CH] one-cycle pulse on each 0->1 of sync_out
//   fall_pulse : [NUM_CH] one-cycle pulse on each 1->0 of sync_out
module sync_filter_multi
    import sync_pkg::*;
#(
    parameter int                NUM_CH        = DEF_NUM_CH,
    parameter int                SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int                FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter logic [NUM_CH-1:0] RESET_VAL     = {NUM_CH{1'b0}}
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [NUM_CH-1:0] async_in,
    output logic [NUM_CH-1:0] sync_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse
);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            sync_filter_chan #(
                .SYNC_STAGES  (SYNC_STAGES),
                .FILTER_CYCLES(FILTER_CYCLES),
                .RESET_BIT    (RESET_VAL[i])
            ) u_chan (
                .clk       (clk),
                .n_rst     (n_rst),
                .async_in  (async_in[i]),
                .sync_out  (sync_out[i]),
                .rise_pulse(rise_pulse[i]),
                .fall_pulse(fall_pulse[i])
            );
        end
    endgenerate

endmodule

// File: doc/sync_filter_multi.md
Name: sync_filter_multi

Overview:
- Parametrised, multi-channel successor to the two-flop input synchronizer.
- Per channel it provides an N-stage metastability chain, an optional stable-count glitch filter, and single-cycle rise/fall pulses.
- Sits at the chip boundary between asynchronous pins (buttons, serial lines, handshake strobes) and downstream FSMs, which consume the pulses directly.

Parameters:
- NUM_CH, 4: number of independent channels.
- SYNC_STAGES, 2: flops in each synchronizer chain; legal range 2 or more.
- FILTER_CYCLES, 3: consecutive cycles a synced value must differ from sync_out before sync_out changes. 0 means filter bypassed.
- RESET_VAL, {NUM_CH{1'b0}}: per-channel reset level for the chain flops, sync_out and sync_out_d.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  reset. Asynchronous, active-low.
- async_in  input  NUM_CH  asynchronous inputs.
- sync_out  output  NUM_CH  synchronized, filtered level.
- rise_pulse  output  NUM_CH  one-cycle high on each 0->1 of sync_out.
- fall_pulse  output  NUM_CH  one-cycle high on each 1->0 of sync_out.

Behaviour:
- Reset state (n_rst=0), applied immediately and independent of clk:
  - all chain flops, sync_out and sync_out_d = RESET_VAL;
  - filter counters = 0;
  - rise_pulse = fall_pulse = 0.
- Chain: stage[0] <= async_in[i]; stage[k] <= stage[k-1]. s_i denotes the last stage.
- Bypass (FILTER_CYCLES=0):
  - sync_out[i] is s_i itself, not an extra flop.
  - Latency SYNC_STAGES edges; identical timing to the legacy two-flop block.
- Filter (FILTER_CYCLES=N>=1), per channel, width $clog2(N+1) counter cnt:
  - s_i == sync_out[i]: cnt <= 0.
  - mismatch and cnt < N-1: cnt <= cnt+1.
  - mismatch and cnt == N-1: sync_out[i] <= s_i, cnt <= 0.
- Filter latency and rejection:
  - Latency from async change (settled before edge 1) to sync_out change is SYNC_STAGES+N edges.
  - A synced level held fewer than N cycles is fully rejected.
  - A level held exactly N cycles passes.
- Edge pulses:
  - sync_out_d <= sync_out every edge.
  - rise_pulse = sync_out & ~sync_out_d; fall_pulse = ~sync_out & sync_out_d.
  - Both are decoded from registers only (glitch-free) and are high exactly in the first cycle sync_out shows its new value.
- Channel independence: channels are fully independent; simultaneous events on different channels produce simultaneous pulses.
- Exclusivity: rise_pulse[i] and fall_pulse[i] are never both 1.
- Release from reset: no pulse is generated on the first edges after n_rst rises, because sync_out == sync_out_d == RESET_VAL.
- Reset mid-filter: any in-progress count is discarded. After release, a still-active input requires the full SYNC_STAGES+N latency again.
- Input toggling every cycle with N>=2: sync_out never changes.

Decomposition:
- Package sync_pkg holds:
  - function cnt_width(N) returning $clog2(N+1), minimum 1;
  - localparam default values for the parameters above.
- One sub-module, sync_filter_chan: single channel containing chain, counter, sync_out_d and pulse decode; parameters SYNC_STAGES, FILTER_CYCLES, RESET_BIT.
- Top level is a generate loop over NUM_CH that passes RESET_VAL[i].

Test Plan (defaults unless stated):
- Hold n_rst=0 with async_in=4'hF for 3 clocks -> sync_out=4'h0, rise_pulse=fall_pulse=0 throughout. Release -> still no pulses for 2 edges.
- async_in[0] 0->1 mid-cycle before edge 1 and held -> sync_out[0]=1 after edge 5. rise_pulse[0]=1 only in the cycle after edge 5; other channels unchanged.
- async_in[1] high for exactly 2 clocks -> sync_out[1] stays 0, no pulses. Repeat with 3 clocks -> sync_out[1] rises after edge 5, falls after edge 8, with one rise_pulse and one fall_pulse.
- Start with sync_out[2]=1; drop async_in[2] and raise async_in[3] in the same cycle -> fall_pulse[2] and rise_pulse[3] asserted in the same cycle, each 1 cycle wide.
- Raise async_in[0]; assert n_rst when the counter is at 2 -> sync_out[0]=0 immediately. Release with input still high -> sync_out[0]=1 exactly 5 edges after release.
- FILTER_CYCLES=0, RESET_VAL=4'b1010:
  - After reset, sync_out=4'b1010 with no pulses.
  - async_in=4'b0101 -> sync_out=4'b0101 after edge 2, rise_pulse=4'b0101 and fall_pulse=4'b1010 for one cycle.
